// File: rtl/bldc_duty_scheduler.sv
// rtl/bldc_duty_scheduler.sv - shares one 8x8 multiplier across the u/v/w duty computations
// Snapshots inputs at period start, computes sin*voltage/SCALE_DIV per phase, commits all three at once.
module bldc_duty_scheduler #(
  parameter int SCALE_DIV   = 100,
  parameter int MUL_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        period_start,
  input  logic [7:0]  voltage,
  input  logic [7:0]  sin_u,
  input  logic [7:0]  sin_v,
  input  logic [7:0]  sin_w,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_load,
  input  logic        mul_valid,
  input  logic [15:0] mul_prod,
  output logic [7:0]  dty_u,
  output logic [7:0]  dty_v,
  output logic [7:0]  dty_w,
  output logic        update,
  output logic        busy,
  output logic        overrun,
  output logic        fault
);
  localparam int TW = $clog2(MUL_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, COMMIT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [7:0]      volt_q, volt_d;
  logic [2:0][7:0] sin_q, sin_d;
  logic [2:0][7:0] shadow_q, shadow_d;
  logic [2:0][7:0] dty_q, dty_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic            mul_load_q, mul_load_d;
  logic            update_q, update_d, busy_q, busy_d;
  logic            overrun_q, overrun_d, fault_q, fault_d;
  logic [15:0]     quot;
  logic [7:0]      quot_sat;
  logic [7:0]      next_sin;

  assign quot     = mul_prod / 16'(SCALE_DIV);
  assign quot_sat = (quot > 16'd255) ? 8'hFF : quot[7:0];

  // Operand for the phase following the current one (only used leaving GAP with phase<2).
  always_comb begin
    case (phase_q)
      2'd0:    next_sin = sin_q[1];
      default: next_sin = sin_q[2];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    volt_d    = volt_q;
    sin_d     = sin_q;
    shadow_d  = shadow_q;
    dty_d     = dty_q;
    tmo_d     = tmo_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    update_d  = 1'b0;
    fault_d   = fault_q;
    overrun_d = overrun_q | (period_start & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (period_start && enable) begin
          volt_d  = voltage;
          sin_d   = {sin_w, sin_v, sin_u};
          phase_d = 2'd0;
          mul_a_d = sin_u;
          mul_b_d = voltage;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_valid) begin
          case (phase_q)
            2'd0:    shadow_d[0] = quot_sat;
            2'd1:    shadow_d[1] = quot_sat;
            default: shadow_d[2] = quot_sat;
          endcase
          state_d = GAP;
        end else if (tmo_q == TW'(MUL_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        if (phase_q != 2'd2) begin
          phase_d = phase_q + 2'd1;
          mul_a_d = next_sin;
          mul_b_d = volt_q;
          state_d = ISSUE;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        dty_d    = shadow_q;
        update_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Disabling aborts any sequence and forces the committed duties to zero.
    if (!enable) begin
      state_d  = IDLE;
      dty_d    = '0;
      update_d = 1'b0;
    end
    mul_load_d = (state_d == ISSUE) || (state_d == WAIT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      volt_q     <= '0;
      sin_q      <= '0;
      shadow_q   <= '0;
      dty_q      <= '0;
      tmo_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_load_q <= 1'b0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      volt_q     <= volt_d;
      sin_q      <= sin_d;
      shadow_q   <= shadow_d;
      dty_q      <= dty_d;
      tmo_q      <= tmo_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_load_q <= mul_load_d;
      update_q   <= update_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      fault_q    <= fault_d;
    end
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign mul_load = mul_load_q;
  assign dty_u    = dty_q[0];
  assign dty_v    = dty_q[1];
  assign dty_w    = dty_q[2];
  assign update   = update_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_bldc_duty_scheduler.sv
// tb/tb_bldc_duty_scheduler.sv - bench for bldc_duty_scheduler
// Vector table, hand-written corner sequences and randomized runs against an arithmetic duty model.
module tb_bldc_duty_scheduler;
  logic        clk = 1'b0;
  logic        rst, enable, period_start;
  logic [7:0]  voltage, sin_u, sin_v, sin_w;
  logic [7:0]  mul_a, mul_b;
  logic        mul_load;
  logic        mul_valid = 1'b0;
  logic [15:0] mul_prod = 16'd0;
  logic [7:0]  dty_u, dty_v, dty_w;
  logic        update, busy, overrun, fault;

  bldc_duty_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .period_start(period_start),
    .voltage(voltage), .sin_u(sin_u), .sin_v(sin_v), .sin_w(sin_w),
    .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load),
    .mul_valid(mul_valid), .mul_prod(mul_prod),
    .dty_u(dty_u), .dty_v(dty_v), .dty_w(dty_w),
    .update(update), .busy(busy), .overrun(overrun), .fault(fault)
  );

  always #5 clk = ~clk;

  // External multiplier: result L cycles after mul_load rises, optional stale strobe one cycle later.
  int   mul_lat = 1;
  bit   mul_dead = 1'b0;
  bit   mul_dup = 1'b0;
  bit   stale_pend = 1'b0;
  logic mul_load_prev = 1'b0;
  int   mcnt = 0;

  always @(posedge clk) begin
    mul_load_prev <= mul_load;
    mul_valid     <= 1'b0;
    if (stale_pend) begin
      mul_valid  <= 1'b1;
      mul_prod   <= 16'hFFFF;
      stale_pend <= 1'b0;
    end
    if (mul_load && !mul_load_prev && !mul_dead) begin
      if (mul_lat <= 1) begin
        mul_valid  <= 1'b1;
        mul_prod   <= 16'(mul_a) * 16'(mul_b);
        stale_pend <= mul_dup;
      end else begin
        mcnt <= mul_lat - 1;
      end
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mul_valid  <= 1'b1;
        mul_prod   <= 16'(mul_a) * 16'(mul_b);
        stale_pend <= mul_dup;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int ref_duty(input int s, input int v);
    int q;
    q = (s * v) / 100;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse period_start for one cycle (cycle T); returns in cycle T+1.
  task automatic start(input int v, input int su, input int sv, input int sw);
    voltage = 8'(v); sin_u = 8'(su); sin_v = 8'(sv); sin_w = 8'(sw);
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
  endtask

  // n = cycle offset from T at which update is first seen, -1 if never.
  task automatic wait_update(input int base, output int n, output int nbusy);
    n = base;
    nbusy = 0;
    while (update !== 1'b1 && n < 200) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
    if (n >= 200) n = -1;
  endtask

  typedef struct {
    int v, su, sv, sw, eu, ev, ew;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n, nb, cnt, f16, lat;
    int v, su, sv, sw;

    vecs[0] = '{100, 200, 100,   0, 200, 100,   0};
    vecs[1] = '{255, 255,   0,  40, 255,   0, 102};
    vecs[2] = '{  1,   0,  99, 255,   0,   0,   2};
    vecs[3] = '{200, 128, 127,   1, 255, 254,   2};
    vecs[4] = '{100, 255,  99, 101, 255,  99, 101};
    vecs[5] = '{  0, 255, 255, 255,   0,   0,   0};

    rst = 1'b1; enable = 1'b1; period_start = 1'b0;
    voltage = 0; sin_u = 0; sin_v = 0; sin_w = 0;
    repeat (3) tick();
    chk("rst_dty", int'({dty_u, dty_v, dty_w}), 0);
    chk("rst_mul", int'({mul_a, mul_b, mul_load}), 0);
    chk("rst_flags", int'({update, busy, overrun, fault}), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      start(vecs[i].v, vecs[i].su, vecs[i].sv, vecs[i].sw);
      wait_update(1, n, nb);
      chk($sformatf("vec%0d_lat", i), n, 11);
      chk($sformatf("vec%0d_busy_cycles", i), nb, 10);
      chk($sformatf("vec%0d_busy_at_update", i), int'(busy), 0);
      chk($sformatf("vec%0d_dty_u", i), int'(dty_u), vecs[i].eu);
      chk($sformatf("vec%0d_dty_v", i), int'(dty_v), vecs[i].ev);
      chk($sformatf("vec%0d_dty_w", i), int'(dty_w), vecs[i].ew);
      tick();
      chk($sformatf("vec%0d_update_pulse", i), int'(update), 0);
    end

    // Minimum spacing: restart in the cycle update appears.
    start(100, 10, 20, 30);
    wait_update(1, n, nb);
    start(100, 40, 50, 60);
    chk("spacing_overrun", int'(overrun), 0);
    wait_update(1, n, nb);
    chk("spacing_lat", n, 11);
    chk("spacing_dty", int'({dty_u, dty_v, dty_w}), int'({8'd40, 8'd50, 8'd60}));

    // period_start coinciding with COMMIT.
    tick();
    start(100, 1, 1, 1);
    repeat (9) tick();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    chk("commit_overrun", int'(overrun), 1);
    chk("commit_update", int'(update), 1);
    tick();
    chk("commit_no_restart", int'(busy), 0);
    cnt = 0;
    repeat (15) begin tick(); if (update) cnt++; end
    chk("commit_no_second_update", cnt, 0);
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // Inputs changed after the snapshot must not leak into the sequence.
    start(100, 200, 100, 0);
    tick(); tick();
    sin_u = 8'd10; voltage = 8'd7;
    wait_update(3, n, nb);
    chk("snap_lat", n, 11);
    chk("snap_dty", int'({dty_u, dty_v, dty_w}), int'({8'd200, 8'd100, 8'd0}));
    tick();

    // Second period_start at T+5.
    start(50, 100, 200, 40);
    repeat (4) tick();
    period_start = 1'b1; sin_u = 8'd77;
    tick();
    period_start = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    wait_update(6, n, nb);
    chk("ovr_lat", n, 11);
    chk("ovr_dty", int'({dty_u, dty_v, dty_w}), int'({8'd50, 8'd100, 8'd20}));
    cnt = 0;
    repeat (25) begin tick(); if (update) cnt++; end
    chk("ovr_no_second_update", cnt, 0);
    chk("ovr_sticky", int'(overrun), 1);

    // Dead multiplier: timeout after 15 WAIT cycles.
    mul_dead = 1'b1;
    start(100, 1, 2, 3);
    n = 1; f16 = -1;
    while (mul_load && n < 40) begin
      tick();
      n++;
      if (n == 16) f16 = int'(fault);
    end
    chk("to_load_drop", n, 17);
    chk("to_fault_before", f16, 0);
    chk("to_fault", int'(fault), 1);
    chk("to_busy", int'(busy), 0);
    chk("to_dty_kept", int'({dty_u, dty_v, dty_w}), int'({8'd50, 8'd100, 8'd20}));
    mul_dead = 1'b0;
    tick();
    start(100, 200, 100, 0);
    wait_update(1, n, nb);
    chk("to_recover_lat", n, 11);
    chk("to_recover_dty", int'({dty_u, dty_v, dty_w}), int'({8'd200, 8'd100, 8'd0}));
    chk("to_fault_sticky", int'(fault), 1);
    tick();

    // Disable at T+6.
    start(255, 255, 255, 255);
    repeat (5) tick();
    enable = 1'b0;
    tick();
    chk("dis_dty", int'({dty_u, dty_v, dty_w}), 0);
    chk("dis_mul_load", int'(mul_load), 0);
    chk("dis_update_busy", int'({update, busy}), 0);
    chk("dis_flags_kept", int'({overrun, fault}), 3);
    enable = 1'b1;
    cnt = 0;
    repeat (20) begin tick(); if (update) cnt++; end
    chk("dis_no_update", cnt, 0);

    // Reset mid-sequence.
    start(100, 200, 100, 0);
    wait_update(1, n, nb);
    tick();
    start(100, 30, 30, 30);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rstmid_dty", int'({dty_u, dty_v, dty_w}), 0);
    chk("rstmid_mul", int'({mul_a, mul_b, mul_load}), 0);
    chk("rstmid_flags", int'({update, busy, overrun, fault}), 0);
    rst = 1'b0;
    repeat (3) tick();

    // Randomized runs: varied latency, stale strobes, post-snapshot input churn.
    for (int k = 0; k < 40; k++) begin
      lat = int'($urandom_range(1, 4));
      mul_lat = lat;
      mul_dup = 1'($urandom_range(0, 1));
      v = int'($urandom_range(0, 255));
      su = int'($urandom_range(0, 255));
      sv = int'($urandom_range(0, 255));
      sw = int'($urandom_range(0, 255));
      start(v, su, sv, sw);
      tick(); tick();
      voltage = 8'($urandom); sin_u = 8'($urandom); sin_v = 8'($urandom); sin_w = 8'($urandom);
      wait_update(3, n, nb);
      chk($sformatf("rnd%0d_lat(L=%0d)", k, lat), n, 3 * (2 + lat) + 2);
      chk($sformatf("rnd%0d_dty_u", k), int'(dty_u), ref_duty(su, v));
      chk($sformatf("rnd%0d_dty_v", k), int'(dty_v), ref_duty(sv, v));
      chk($sformatf("rnd%0d_dty_w", k), int'(dty_w), ref_duty(sw, v));
      repeat ($urandom_range(1, 3)) tick();
    end
    chk("rnd_no_overrun", int'(overrun), 0);
    chk("rnd_no_fault", int'(fault), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
